// File: rtl/cpu_pkg.sv
// Shared definitions for the processor's fetch/sequencing logic.
package cpu_pkg;

  // Sequencer states: BOOT gives one idle cycle after reset release.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } pc_state_e;

  // Byte distance between consecutive instructions.
  localparam int PC_STEP = 4;

  // Defaults used by the PC datapath and controller parameters.
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int          OFFSET_W_DEF     = 8;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, jump or taken branch.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic [ADDR_W-1:0]   i_pc,
  input  logic                i_jump,
  input  logic                i_beq,
  input  logic                i_bne,
  input  logic                i_zero,
  input  logic [OFFSET_W-1:0] i_offset,
  output logic [ADDR_W-1:0]   o_pc_plus4,
  output logic [ADDR_W-1:0]   o_next_pc
);

  logic              w_taken;
  logic [ADDR_W-1:0] w_off_bytes;
  logic [ADDR_W-1:0] w_target;

  // BEQ and BNE together always resolve to taken, since exactly one matches ZERO.
  assign w_taken = i_jump | (i_beq & i_zero) | (i_bne & ~i_zero);

  // Word offset sign-extended and scaled to bytes; all sums wrap modulo 2^ADDR_W.
  assign w_off_bytes = {{(ADDR_W-OFFSET_W-2){i_offset[OFFSET_W-1]}}, i_offset, 2'b00};
  assign o_pc_plus4  = i_pc + ADDR_W'(PC_STEP);
  assign w_target    = o_pc_plus4 + w_off_bytes;

  // Mux rather than arithmetic blend so an unknown offset cannot leak into a not-taken PC.
  assign o_next_pc = w_taken ? w_target : o_pc_plus4;

endmodule

// File: rtl/pc_controller.sv
// Program counter owner: BOOT/RUN/STALL sequencing, busywait freeze and stall debug counters.
module pc_controller
  import cpu_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
  parameter int                OFFSET_W     = OFFSET_W_DEF,
  parameter int                MAX_STALL    = 255,
  parameter int                CNT_W        = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                BUSYWAIT_I,
  input  logic                BUSYWAIT_D,
  input  logic                JUMP,
  input  logic                BEQ,
  input  logic                BNE,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   PC_PLUS4,
  output logic                FETCH_EN,
  output logic [CNT_W-1:0]    STALL_CNT,
  output logic                STALL_ERR
);

  // Run-length only needs to count up to MAX_STALL+1, where it saturates.
  localparam int               RUN_W     = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  pc_state_e         r_state;
  pc_state_e         w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [RUN_W-1:0]  r_run_len;
  logic [RUN_W-1:0]  w_run_next;
  logic              r_stall_err;
  logic              w_busy;
  logic              w_pc_load;
  logic              w_stall_edge;
  logic              w_fetch_en;

  assign w_busy = BUSYWAIT_I | BUSYWAIT_D;

  pc_next_calc #(
    .ADDR_W   (ADDR_W),
    .OFFSET_W (OFFSET_W)
  ) u_pc_next_calc (
    .i_pc       (r_pc),
    .i_jump     (JUMP),
    .i_beq      (BEQ),
    .i_bne      (BNE),
    .i_zero     (ZERO),
    .i_offset   (OFFSET),
    .o_pc_plus4 (w_pc_plus4),
    .o_next_pc  (w_next_pc)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= BOOT;
    else        r_state <= w_state_next;
  end

  // Next-state, PC load enable, stall bookkeeping and fetch-enable decode.
  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_stall_edge = 1'b0;
    w_fetch_en   = 1'b0;
    w_run_next   = '0;
    case (r_state)
      BOOT: begin
        w_state_next = RUN;
      end
      RUN: begin
        w_fetch_en = 1'b1;
        if (w_busy) begin
          w_state_next = STALL;
          w_stall_edge = 1'b1;
          w_run_next   = RUN_W'(1);
        end else begin
          w_pc_load = 1'b1;
        end
      end
      STALL: begin
        w_fetch_en = 1'b1;
        if (w_busy) begin
          w_stall_edge = 1'b1;
          w_run_next   = (r_run_len == RUN_LIMIT) ? RUN_LIMIT : r_run_len + RUN_W'(1);
        end else begin
          w_state_next = RUN;
          w_pc_load    = 1'b1;
        end
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  // PC register: frozen in BOOT and while any memory is busy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         r_pc <= RESET_VECTOR;
    else if (w_pc_load) r_pc <= w_next_pc;
  end

  // Saturating total stall count, current stall run-length and sticky timeout flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_stall_cnt <= '0;
      r_run_len   <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_run_len <= w_run_next;
      if (w_stall_edge && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_stall_edge && (w_run_next == RUN_LIMIT)) r_stall_err <= 1'b1;
    end
  end

  assign PC        = r_pc;
  assign PC_PLUS4  = w_pc_plus4;
  assign FETCH_EN  = w_fetch_en;
  assign STALL_CNT = r_stall_cnt;
  assign STALL_ERR = r_stall_err;

endmodule
